// File: rtl/sample_buffer_ctrl.sv
// Sample RAM sequencer and arbiter for the Veritune voice path.
// Shares one single-port RAM between the record path (mic samples in), the
// pitch shifter (read-modify-write) and the playback path (speaker out).
// It generates the audio sample-rate tick, owns the record and playback
// address counters and keeps the recorded length between modes.
// TICK_DIV must be at least 2.
module sample_buffer_ctrl #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int TICK_DIV = 6250
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Rec,
  input  logic              Shift,
  input  logic              Play,
  input  logic [DATA_W-1:0] Mic_Sample,
  input  logic              Sh_Rd_Req,
  input  logic              Sh_Wr_Req,
  input  logic [ADDR_W-1:0] Sh_Addr,
  input  logic [DATA_W-1:0] Sh_Wdata,
  output logic              Sh_Gnt,
  output logic              Sh_Rvalid,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_We,
  output logic [DATA_W-1:0] Mem_Wdata,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic [DATA_W-1:0] Spk_Sample,
  output logic              Spk_Valid,
  output logic [ADDR_W:0]   Rec_Len,
  output logic              Rec_Done,
  output logic              Play_Done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  TICK_PRE  = CNT_W'(TICK_DIV - 2);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] RD_ONE    = ADDR_W'(1);
  // Address of the last RAM location, widened to the record pointer width.
  localparam logic [ADDR_W:0]   LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REC   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PLAY  = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   state_chg;

  // Sample-rate divider.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             pre_tick;

  // Record path. wr_ptr has one extra bit so "buffer full" is representable.
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rec_len_q, rec_len_d;
  logic            rec_done_q, rec_done_d;
  logic            rec_wr;

  // Shifter port.
  logic sh_wr;
  logic sh_rd;
  logic sh_rvalid_q, sh_rvalid_d;

  // Playback path.
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              play_rd;
  logic              play_last;
  logic              play_empty_pulse;
  logic              empty_done_q, empty_done_d;
  logic              spk_pend_q, spk_pend_d;
  logic              spk_last_q, spk_last_d;
  logic [DATA_W-1:0] spk_sample_q, spk_sample_d;
  logic              spk_valid_q, spk_valid_d;
  logic              play_done_q, play_done_d;

  // RAM address seen last cycle, re-driven while the port is idle.
  logic [ADDR_W-1:0] mem_addr_q;

  // ---------------------------------------------------------------------
  // Mode decode
  // ---------------------------------------------------------------------

  // Next state straight from the mode levels, record having top priority.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = ST_IDLE;
    if (Rec) begin
      state_d = ST_REC;
    end else if (Shift) begin
      state_d = ST_SHIFT;
    end else if (Play) begin
      state_d = ST_PLAY;
    end
  end

  assign state_chg = (state_d != state_q);

  // ---------------------------------------------------------------------
  // Sample-rate tick
  // ---------------------------------------------------------------------

  assign tick     = (cnt_q == TICK_LAST);
  assign pre_tick = (cnt_q == TICK_PRE);

  // Divider restarts on every mode change so the first tick of a mode comes
  // a full sample period after entry.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (state_chg || tick) begin
      cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Record path
  // ---------------------------------------------------------------------

  assign rec_wr = (state_q == ST_REC) && tick && !wr_ptr_q[ADDR_W];

  // Write pointer, recorded length and the buffer-full pulse.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rec_len_d  = rec_len_q;
    rec_done_d = 1'b0;
    if (rec_wr) begin
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
      rec_len_d  = wr_ptr_q + PTR_ONE;
      rec_done_d = (wr_ptr_q == LAST_ADDR);
    end
    // A new recording discards the old one.
    if (state_chg && (state_d == ST_REC)) begin
      wr_ptr_d  = '0;
      rec_len_d = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Shifter arbitration
  // ---------------------------------------------------------------------

  // A write wins over a simultaneous read; the read is simply not granted.
  assign sh_wr  = (state_q == ST_SHIFT) && Sh_Wr_Req;
  assign sh_rd  = (state_q == ST_SHIFT) && Sh_Rd_Req && !Sh_Wr_Req;
  assign Sh_Gnt = sh_wr || sh_rd;

  // Read-valid follows a granted read unless the mode is about to change.
  always_comb begin
    sh_rvalid_d = sh_rd && !state_chg;
  end

  // ---------------------------------------------------------------------
  // Playback path
  // ---------------------------------------------------------------------

  assign play_rd   = (state_q == ST_PLAY) && tick && (rec_len_q != '0);
  assign play_last = ({1'b0, rd_ptr_q} == (rec_len_q - PTR_ONE));

  // With nothing recorded, Play_Done is registered one cycle early so that
  // it appears on the first tick itself, and only once per visit.
  assign play_empty_pulse = (state_q == ST_PLAY) && (rec_len_q == '0) &&
                            pre_tick && !empty_done_q && !state_chg;

  // Read pointer, in-flight read tracking and speaker sample capture.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    empty_done_d = empty_done_q;
    spk_pend_d   = 1'b0;
    spk_last_d   = 1'b0;
    spk_sample_d = spk_sample_q;
    spk_valid_d  = 1'b0;
    play_done_d  = 1'b0;
    // RAM data for last cycle's read is on Mem_Rdata now.
    if (spk_pend_q) begin
      spk_sample_d = Mem_Rdata;
      spk_valid_d  = 1'b1;
      play_done_d  = spk_last_q;
    end
    // A read issued as the mode changes is dropped and Spk_Sample holds.
    if (play_rd) begin
      spk_pend_d = !state_chg;
      spk_last_d = !state_chg && play_last;
      rd_ptr_d   = play_last ? '0 : rd_ptr_q + RD_ONE;
    end
    if (play_empty_pulse) begin
      play_done_d  = 1'b1;
      empty_done_d = 1'b1;
    end
    if (state_chg && (state_d == ST_PLAY)) begin
      rd_ptr_d     = '0;
      empty_done_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // RAM port mux
  // ---------------------------------------------------------------------

  // Sources are mutually exclusive by state; an idle port keeps its address.
  always_comb begin
    Mem_Addr  = mem_addr_q;
    Mem_We    = 1'b0;
    Mem_Wdata = '0;
    if (rec_wr) begin
      Mem_Addr  = wr_ptr_q[ADDR_W-1:0];
      Mem_We    = 1'b1;
      Mem_Wdata = Mic_Sample;
    end else if (sh_wr) begin
      Mem_Addr  = Sh_Addr;
      Mem_We    = 1'b1;
      Mem_Wdata = Sh_Wdata;
    end else if (sh_rd) begin
      Mem_Addr = Sh_Addr;
    end else if (play_rd) begin
      Mem_Addr = rd_ptr_q;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------

  // All state; reset aborts everything and drops the recording.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rec_len_q    <= '0;
      rec_done_q   <= 1'b0;
      sh_rvalid_q  <= 1'b0;
      rd_ptr_q     <= '0;
      empty_done_q <= 1'b0;
      spk_pend_q   <= 1'b0;
      spk_last_q   <= 1'b0;
      spk_sample_q <= '0;
      spk_valid_q  <= 1'b0;
      play_done_q  <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // values of the previous cycle regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rec_len_q    <= rec_len_d;
      rec_done_q   <= rec_done_d;
      sh_rvalid_q  <= sh_rvalid_d;
      rd_ptr_q     <= rd_ptr_d;
      empty_done_q <= empty_done_d;
      spk_pend_q   <= spk_pend_d;
      spk_last_q   <= spk_last_d;
      spk_sample_q <= spk_sample_d;
      spk_valid_q  <= spk_valid_d;
      play_done_q  <= play_done_d;
      mem_addr_q   <= Mem_Addr;
    end
  end

  assign Sh_Rvalid  = sh_rvalid_q;
  assign Spk_Sample = spk_sample_q;
  assign Spk_Valid  = spk_valid_q;
  assign Rec_Len    = rec_len_q;
  assign Rec_Done   = rec_done_q;
  assign Play_Done  = play_done_q;

endmodule
